// File: rtl/ahb_master_req_ctrl_pkg.sv
// rtl/ahb_master_req_ctrl_pkg.sv - shared FSM state type and default sizing for the AHB master request controller
package AHB_package;

  localparam int DEF_PRIOR_LEVEL = 3;
  localparam int DEF_MAX_BEAT    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_e;

  // $clog2 that never returns zero, so a counter for a threshold of 1 still has one bit
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/ahb_master_req_ctrl_if.sv
// rtl/ahb_master_req_ctrl_if.sv - command and arbiter-side signal bundle of the AHB master request controller
interface ahb_master_req_ctrl_if #(
  parameter int PRIOR_BIT = 2,
  parameter int LEN_BIT   = 4
);

  logic                 cmd_valid;
  logic [LEN_BIT-1:0]   cmd_len;
  logic [PRIOR_BIT-1:0] cmd_prior;
  logic                 cmd_ready;
  logic                 hreq;
  logic                 hlast;
  logic [PRIOR_BIT-1:0] hprior;
  logic                 hgrant;
  logic                 beat_en;
  logic [LEN_BIT-1:0]   beat_cnt;
  logic                 done;

  // controller side
  modport master (
    input  cmd_valid, cmd_len, cmd_prior, hgrant,
    output cmd_ready, hreq, hlast, hprior, beat_en, beat_cnt, done
  );

  // core and arbiter side
  modport slave (
    output cmd_valid, cmd_len, cmd_prior, hgrant,
    input  cmd_ready, hreq, hlast, hprior, beat_en, beat_cnt, done
  );

endinterface

// File: rtl/ahb_master_req_ctrl_prior_aging.sv
// rtl/ahb_master_req_ctrl_prior_aging.sv - wait-time priority boost with saturation (used only with PRIORITY_AGING_EN)
import AHB_package::*;

module ahb_prior_aging #(
  parameter int PRIOR_LEVEL = DEF_PRIOR_LEVEL,
  parameter int PRIOR_BIT   = $clog2(PRIOR_LEVEL),
  parameter int AGE_THRESH  = 8
) (
  input  logic                 hclk,
  input  logic                 hreset_n,
  input  logic                 hreq,
  input  logic                 hgrant,
  input  logic                 done,
  input  logic [PRIOR_BIT-1:0] prior_q,
  output logic [PRIOR_BIT-1:0] hprior
);

  localparam int AGE_BIT = clog2_min1(AGE_THRESH);
  localparam int SUM_BIT = PRIOR_BIT + 1;

  logic [AGE_BIT-1:0]   age_q;
  logic [PRIOR_BIT-1:0] boost_q;
  logic                 stall;
  logic                 step;
  logic [SUM_BIT-1:0]   sum;

  // a stalled request cycle ages; a granted beat or IDLE restarts the wait
  assign stall = hreq & ~hgrant;
  assign step  = stall & (age_q == AGE_BIT'(AGE_THRESH - 1));

  // wait-cycle counter, wraps to zero on every priority step
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      age_q <= '0;
    end else if (!stall || step) begin
      age_q <= '0;
    end else begin
      age_q <= age_q + 1'b1;
    end
  end

  // boost accumulates across beats of one transaction and stops at the top level
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      boost_q <= '0;
    end else if (done) begin
      boost_q <= '0;
    end else if (step && (boost_q != PRIOR_BIT'(PRIOR_LEVEL - 1))) begin
      boost_q <= boost_q + 1'b1;
    end
  end

  // extra bit on the sum so the saturation compare cannot be fooled by a wrap
  always_comb begin
    sum    = {1'b0, prior_q} + {1'b0, boost_q};
    hprior = '0;
    if (hreq) begin
      if (sum > SUM_BIT'(PRIOR_LEVEL - 1)) hprior = PRIOR_BIT'(PRIOR_LEVEL - 1);
      else                                 hprior = sum[PRIOR_BIT-1:0];
    end
  end

endmodule

// File: rtl/ahb_master_req_ctrl.sv
// rtl/ahb_master_req_ctrl.sv - AHB master request/beat controller; optional priority aging under PRIORITY_AGING_EN
import AHB_package::*;

module ahb_master_req_ctrl #(
  parameter int PRIOR_LEVEL = DEF_PRIOR_LEVEL,
  parameter int PRIOR_BIT   = $clog2(PRIOR_LEVEL),
  parameter int MAX_BEAT    = DEF_MAX_BEAT,
  parameter int LEN_BIT     = $clog2(MAX_BEAT),
  parameter int AGE_THRESH  = 8
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  ahb_master_req_ctrl_if.master bus
);

  state_e               state_q;
  state_e               state_d;
  logic [LEN_BIT-1:0]   len_q;
  logic [LEN_BIT-1:0]   cnt_q;
  logic [PRIOR_BIT-1:0] prior_q;
  logic                 busy;
  logic                 last;
  logic                 beat;
  logic                 accept;

  // everything seen by the arbiter is decoded from registered state, grant is the only same-cycle input
  assign busy   = (state_q != IDLE);
  assign last   = busy && (cnt_q == len_q);
  assign beat   = busy && bus.hgrant;
  assign accept = (state_q == IDLE) && bus.cmd_valid;

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.hreq      = busy;
  assign bus.hlast     = last;
  assign bus.beat_en   = beat;
  assign bus.beat_cnt  = cnt_q;
  assign bus.done      = beat && last;

  // state register
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // next state: a transfer only ends on its last accepted beat, never abandoned
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.cmd_valid) state_d = REQ;
      REQ, XFER: if (beat) state_d = last ? IDLE : XFER;
      default:   state_d = IDLE;
    endcase
  end

  // command capture in IDLE and beat counting; the count holds through stalls and after the last beat
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      len_q   <= '0;
      prior_q <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      len_q   <= bus.cmd_len;
      prior_q <= bus.cmd_prior;
      cnt_q   <= '0;
    end else if (beat && !last) begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

`ifdef PRIORITY_AGING_EN
  ahb_prior_aging #(
    .PRIOR_LEVEL (PRIOR_LEVEL),
    .PRIOR_BIT   (PRIOR_BIT),
    .AGE_THRESH  (AGE_THRESH)
  ) u_prior_aging (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .hreq     (busy),
    .hgrant   (bus.hgrant),
    .done     (bus.done),
    .prior_q  (prior_q),
    .hprior   (bus.hprior)
  );
`else
  logic unused_cfg;

  // priority is the captured base level while busy
  assign bus.hprior = busy ? prior_q : '0;
  assign unused_cfg = ^{AGE_THRESH, PRIOR_LEVEL, MAX_BEAT};
`endif

endmodule
